glyph_encoder: RTL and testbench

- Recovers the decimal digit from a serial stream of 13-bit glyph patterns, in the a..m segment order used by the score display.
- Used on the readback/self-check path: display frames captured from the playfield renderer are shifted in and converted back to digits, so score and level values can be checked on-chip.
- Sits between the glyph capture shifter and the score checker, with a valid/ready handshake on both sides.

---
 rtl/glyph_encoder_if.sv | 22 ++
 rtl/glyph_encoder.sv | 146 ++++++++++++++
 tb/tb_glyph_encoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/glyph_encoder_if.sv
// glyph_encoder_if: serial glyph input and decoded digit output handshakes.
// The master side feeds bits and consumes results; the slave side is the encoder.
interface glyph_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_err;

  modport master (
    output in_valid, in_bit, in_sof, out_ready,
    input  in_ready, out_valid, out_digit, out_err
  );

  modport slave (
    input  in_valid, in_bit, in_sof, out_ready,
    output in_ready, out_valid, out_digit, out_err
  );
endinterface

// File: rtl/glyph_encoder.sv
// glyph_encoder: recovers decimal digits from a serial stream of 13-bit
// a..m segment glyphs captured off the score display.
// Optional statistics counters (glyph_cnt, err_cnt) are built only when
// GLYPH_ENC_STATS_EN is defined; otherwise both outputs are tied to 0.
module glyph_encoder #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  glyph_encoder_if.slave  bus,
  output logic [7:0]      glyph_cnt,
  output logic [7:0]      err_cnt
);

  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] shreg_q, shreg_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_digit_q, out_digit_d;
  logic        out_err_q, out_err_d;

  logic        accept;
  logic        complete;
  logic [3:0]  pos;
  logic [12:0] glyph_next;
  logic [3:0]  dec_digit;
  logic        dec_err;

  // Only the 13th bit has to wait for the held result to be taken.
  assign bus.in_ready = (cnt_q != 4'd12) || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pos          = bus.in_sof ? 4'd0 : cnt_q;
  assign complete     = accept && (pos == 4'd12);

  assign bus.out_valid = out_valid_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_err   = out_err_q;

  // Shift the incoming bit in so the register always ends up as {a..m}.
  always_comb begin
    if (MSB_FIRST) begin
      glyph_next = {shreg_q[11:0], bus.in_bit};
    end else begin
      glyph_next = {bus.in_bit, shreg_q[12:1]};
    end
  end

  // Exact-match lookup of the completed glyph against the digit table.
  always_comb begin
    dec_err = 1'b0;
    case (glyph_next)
      13'b1111111111110: dec_digit = 4'd0;
      13'b1111100000000: dec_digit = 4'd1;
      13'b1110111110111: dec_digit = 4'd2;
      13'b1111111010111: dec_digit = 4'd3;
      13'b1111100011101: dec_digit = 4'd4;
      13'b1011111011111: dec_digit = 4'd5;
      13'b1011111111111: dec_digit = 4'd6;
      13'b1111100000110: dec_digit = 4'd7;
      13'b1111111111111: dec_digit = 4'd8;
      13'b1111100011111: dec_digit = 4'd9;
      default: begin
        dec_digit = 4'hF;
        dec_err   = 1'b1;
      end
    endcase
  end

  // Next-state: bit position, shift register and the held result.
  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    out_valid_d = out_valid_q;
    out_digit_d = out_digit_q;
    out_err_d   = out_err_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      shreg_d = glyph_next;
      cnt_d   = complete ? 4'd0 : pos + 4'd1;
    end
    if (complete) begin
      out_valid_d = 1'b1;
      out_digit_d = dec_digit;
      out_err_d   = dec_err;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      shreg_q     <= 13'd0;
      out_valid_q <= 1'b0;
      out_digit_q <= 4'd0;
      out_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef GLYPH_ENC_STATS_EN
  logic [7:0] glyph_cnt_q, glyph_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       trunc;
  logic       err_event;

  // A start-of-frame bit arriving mid-glyph throws away the partial glyph.
  assign trunc     = accept && bus.in_sof && (cnt_q != 4'd0);
  assign err_event = (complete && dec_err) || trunc;

  // Saturating counters; one error event per cycle at most.
  always_comb begin
    glyph_cnt_d = glyph_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (complete && (glyph_cnt_q != 8'hFF)) begin
      glyph_cnt_d = glyph_cnt_q + 8'd1;
    end
    if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      glyph_cnt_q <= glyph_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign glyph_cnt = glyph_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign glyph_cnt = 8'd0;
  assign err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_glyph_encoder.sv
// tb_glyph_encoder: drives an MSB-first and an LSB-first encoder with the same
// glyphs (bit order reversed for the LSB-first one) and scoreboards both.
module tb_glyph_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic in_valid, in_sof, bit_m, bit_l, out_ready;
  logic [7:0] gc_m, ec_m, gc_l, ec_l;

  glyph_encoder_if bus_m ();
  glyph_encoder_if bus_l ();

  assign bus_m.in_valid  = in_valid;
  assign bus_m.in_sof    = in_sof;
  assign bus_m.in_bit    = bit_m;
  assign bus_m.out_ready = out_ready;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.in_sof    = in_sof;
  assign bus_l.in_bit    = bit_l;
  assign bus_l.out_ready = out_ready;

  glyph_encoder #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(bus_m), .glyph_cnt(gc_m), .err_cnt(ec_m)
  );
  glyph_encoder #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(bus_l), .glyph_cnt(gc_l), .err_cnt(ec_l)
  );

  int n_checks = 0;
  int n_bad    = 0;

  logic [12:0] glyph_tab [10];
  logic [4:0]  exp_m [$];
  logic [4:0]  exp_l [$];
  logic [4:0]  em, el;

  int bench_cnt = 0;
  int exp_gc    = 0;
  int exp_ec    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [12:0] g);
    for (int d = 0; d < 10; d++) begin
      if (glyph_tab[d] == g) return {1'b0, 4'(d)};
    end
    return 5'b1_1111;
  endfunction

  // Model of one accepted bit: position tracking, truncation, completion.
  task automatic model_accept(input logic [12:0] g, input logic sof);
    int p;
    logic [4:0] r;
    if (sof && bench_cnt != 0) exp_ec++;
    p = sof ? 0 : bench_cnt;
    if (p == 12) begin
      r = ref_decode(g);
      exp_m.push_back(r);
      exp_l.push_back(r);
      exp_gc++;
      if (r[4]) exp_ec++;
      bench_cnt = 0;
    end else begin
      bench_cnt = p + 1;
    end
  endtask

  task automatic send_bit(input logic [12:0] g, input int idx, input logic sof, output int stalls);
    bit_m    = g[12-idx];
    bit_l    = g[idx];
    in_sof   = sof;
    in_valid = 1'b1;
    stalls   = 0;
    @(negedge clk);
    while (!bus_m.in_ready && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 40) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    model_accept(g, sof);
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] g, input int nbits, output int stalls_total);
    int s;
    stalls_total = 0;
    for (int i = 0; i < nbits; i++) begin
      send_bit(g, i, (i == 0), s);
      stalls_total += s;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic checkCounters(input string tag);
`ifdef GLYPH_ENC_STATS_EN
    checkOutput({tag, "_gc_m"}, 32'(gc_m), 32'(exp_gc));
    checkOutput({tag, "_ec_m"}, 32'(ec_m), 32'(exp_ec));
    checkOutput({tag, "_gc_l"}, 32'(gc_l), 32'(exp_gc));
    checkOutput({tag, "_ec_l"}, 32'(ec_l), 32'(exp_ec));
`else
    checkOutput({tag, "_gc_m"}, 32'(gc_m), 32'd0);
    checkOutput({tag, "_ec_m"}, 32'(ec_m), 32'd0);
    checkOutput({tag, "_gc_l"}, 32'(gc_l), 32'd0);
    checkOutput({tag, "_ec_l"}, 32'(ec_l), 32'd0);
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdy_m"}, 32'(bus_m.in_ready), 32'd1);
    checkOutput({tag, "_vld_m"}, 32'(bus_m.out_valid), 32'd0);
    checkOutput({tag, "_dig_m"}, 32'(bus_m.out_digit), 32'd0);
    checkOutput({tag, "_err_m"}, 32'(bus_m.out_err), 32'd0);
    checkOutput({tag, "_rdy_l"}, 32'(bus_l.in_ready), 32'd1);
    checkOutput({tag, "_vld_l"}, 32'(bus_l.out_valid), 32'd0);
    checkOutput({tag, "_dig_l"}, 32'(bus_l.out_digit), 32'd0);
    checkOutput({tag, "_err_l"}, 32'(bus_l.out_err), 32'd0);
    checkOutput({tag, "_gc_m"}, 32'(gc_m), 32'd0);
    checkOutput({tag, "_ec_m"}, 32'(ec_m), 32'd0);
  endtask

  // Scoreboard: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && bus_m.out_valid && bus_m.out_ready) begin
      if (exp_m.size() == 0) begin
        checkOutput("msb_unexpected_result", 32'd1, 32'd0);
      end else begin
        em = exp_m.pop_front();
        checkOutput("msb_digit", 32'(bus_m.out_digit), 32'(em[3:0]));
        checkOutput("msb_err", 32'(bus_m.out_err), 32'(em[4]));
      end
    end
    if (rst_n && bus_l.out_valid && bus_l.out_ready) begin
      if (exp_l.size() == 0) begin
        checkOutput("lsb_unexpected_result", 32'd1, 32'd0);
      end else begin
        el = exp_l.pop_front();
        checkOutput("lsb_digit", 32'(bus_l.out_digit), 32'(el[3:0]));
        checkOutput("lsb_err", 32'(bus_l.out_err), 32'(el[4]));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    int stalls;
    glyph_tab[0] = 13'b1111111111110;
    glyph_tab[1] = 13'b1111100000000;
    glyph_tab[2] = 13'b1110111110111;
    glyph_tab[3] = 13'b1111111010111;
    glyph_tab[4] = 13'b1111100011101;
    glyph_tab[5] = 13'b1011111011111;
    glyph_tab[6] = 13'b1011111111111;
    glyph_tab[7] = 13'b1111100000110;
    glyph_tab[8] = 13'b1111111111111;
    glyph_tab[9] = 13'b1111100011111;

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    bit_m = 1'b0; bit_l = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single glyph "9", result pulses for one cycle.
    applyStimulus(glyph_tab[9], 13, s);
    @(negedge clk);
    checkOutput("t1_valid", 32'(bus_m.out_valid), 32'd1);
    checkOutput("t1_digit", 32'(bus_m.out_digit), 32'd9);
    checkCounters("t1");
    @(negedge clk);
    checkOutput("t1_valid_drop", 32'(bus_m.out_valid), 32'd0);

    // All ten glyphs back to back, no stalls expected.
    stalls = 0;
    for (int d = 0; d < 10; d++) begin
      applyStimulus(glyph_tab[d], 13, s);
      stalls += s;
    end
    checkOutput("t2_no_stall", 32'(stalls), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_drained", 32'(exp_m.size() + exp_l.size()), 32'd0);
    checkCounters("t2");

    // Unmatched pattern.
    applyStimulus(13'd0, 13, s);
    @(negedge clk);
    checkOutput("t3_digit", 32'(bus_m.out_digit), 32'hF);
    checkOutput("t3_err", 32'(bus_l.out_err), 32'd1);
    checkCounters("t3");

    // Back-pressure: "3" held while "7" shifts in behind it.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(glyph_tab[3], 13, s);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send_bit(glyph_tab[7], i, (i == 0), s);
      stalls += s;
    end
    checkOutput("t4_first12_no_stall", 32'(stalls), 32'd0);
    bit_m = glyph_tab[7][0];
    bit_l = glyph_tab[7][12];
    in_sof = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready_low", 32'(bus_m.in_ready), 32'd0);
    checkOutput("t4_hold_valid", 32'(bus_m.out_valid), 32'd1);
    checkOutput("t4_hold_digit", 32'(bus_m.out_digit), 32'd3);
    @(negedge clk);
    checkOutput("t4_ready_low2", 32'(bus_l.in_ready), 32'd0);
    checkOutput("t4_hold_digit2", 32'(bus_l.out_digit), 32'd3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready_high", 32'(bus_m.in_ready), 32'd1);
    @(posedge clk);
    model_accept(glyph_tab[7], 1'b0);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_valid_stays", 32'(bus_m.out_valid), 32'd1);
    checkOutput("t4_next_digit", 32'(bus_m.out_digit), 32'd7);
    @(negedge clk);
    checkOutput("t4_valid_drop", 32'(bus_m.out_valid), 32'd0);

    // Truncation: 5 bits then a new start-of-frame with glyph "2".
    applyStimulus(glyph_tab[8], 5, s);
    applyStimulus(glyph_tab[2], 13, s);
    @(negedge clk);
    checkOutput("t5_digit", 32'(bus_m.out_digit), 32'd2);
    checkCounters("t5");

    // Reset while a result is held and a glyph is partly shifted in.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(glyph_tab[1], 13, s);
    applyStimulus(glyph_tab[6], 4, s);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetValues("t6_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bench_cnt = 0; exp_gc = 0; exp_ec = 0;
    exp_m.delete();
    exp_l.delete();
    out_ready = 1'b1;
    applyStimulus(glyph_tab[5], 13, s);
    @(negedge clk);
    checkOutput("t6_digit", 32'(bus_m.out_digit), 32'd5);
    checkOutput("t6_digit_lsb", 32'(bus_l.out_digit), 32'd5);
    checkCounters("t6");
    @(negedge clk);
    @(negedge clk);
    checkOutput("final_drained", 32'(exp_m.size() + exp_l.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
